// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : MIPS instruction fetch stage. Owns the PC, issues word fetches
//            to instruction memory over a req/ready handshake, buffers one
//            returned word in a skid register and presents instructions to
//            decode over a valid/stall handshake. Applies taken branches and
//            jumps from decode, squashing wrong-path fetches.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC     PC loaded on reset
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   imem_req     fetch request, address held stable until imem_ready
//   imem_addr    word-aligned fetch address
//   imem_ready   memory returns imem_rdata this cycle (qualified by imem_req)
//   imem_rdata   fetched instruction word
//   stall        decode cannot accept the presented instruction
//   redirect     taken branch/jump, qualified by if_valid && !stall
//   redirect_pc  redirect target (bits [1:0] ignored)
//   if_valid     if_inst / if_pc hold a valid instruction
//   if_inst      instruction presented to decode
//   if_pc        address of if_inst
//   opcode       if_inst[31:26], feeds control_unit
// Configuration
//   IFETCH_DELAY_SLOT_EN  when defined, a redirect keeps exactly one
//                         sequential instruction (branch delay slot)
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [5:0]  opcode
);

    localparam logic [1:0] c_RUN    = 2'd0;
    localparam logic [1:0] c_SKID   = 2'd1;
    localparam logic [1:0] c_SQUASH = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;        // redirect target waiting to be applied
    logic        r_out_valid;
    logic [31:0] r_out_inst;
    logic [31:0] r_out_pc;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
`ifdef IFETCH_DELAY_SLOT_EN
    logic        r_pend;       // delay-slot fetch in progress, r_tgt follows
`endif

    logic        w_consume;
    logic        w_redirect;
    logic        w_fire;
    logic [31:0] w_tgt;
    logic [31:0] w_pc_inc;

    assign w_consume  = r_out_valid && !stall;
    assign w_redirect = w_consume && redirect;
    assign w_fire     = imem_req && imem_ready;
    assign w_tgt      = {redirect_pc[31:2], 2'b00};
    assign w_pc_inc   = r_pc + 32'd4;

    // Request is gated by rst so it drops in the same cycle reset is seen,
    // aborting any outstanding fetch.
    assign imem_req  = !rst && (r_state != c_SKID);
    assign imem_addr = {r_pc[31:2], 2'b00};

    assign if_valid = r_out_valid;
    assign if_inst  = r_out_inst;
    assign if_pc    = r_out_pc;
    assign opcode   = r_out_inst[31:26];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_RUN;
            r_pc        <= {RESET_PC[31:2], 2'b00};
            r_tgt       <= 32'd0;
            r_out_valid <= 1'b0;
            r_out_inst  <= 32'd0;
            r_out_pc    <= 32'd0;
            r_skid_inst <= 32'd0;
            r_skid_pc   <= 32'd0;
`ifdef IFETCH_DELAY_SLOT_EN
            r_pend      <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_RUN: begin
`ifdef IFETCH_DELAY_SLOT_EN
                    // In RUN with a valid output, the word being fetched is
                    // always if_pc+4, i.e. the delay slot of a redirect.
                    if (w_fire) begin
                        if (!r_out_valid || w_consume) begin
                            r_out_valid <= 1'b1;
                            r_out_inst  <= imem_rdata;
                            r_out_pc    <= imem_addr;
                        end else begin
                            r_skid_inst <= imem_rdata;
                            r_skid_pc   <= imem_addr;
                            r_state     <= c_SKID;
                        end
                        if (w_redirect) begin
                            r_pc <= w_tgt;
                        end else if (r_pend) begin
                            r_pc <= r_tgt;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                        r_pend <= 1'b0;
                    end else begin
                        if (w_consume) begin
                            r_out_valid <= 1'b0;
                        end
                        if (w_redirect) begin
                            r_pend <= 1'b1;
                            r_tgt  <= w_tgt;
                        end
                    end
`else
                    if (w_redirect) begin
                        // The same-cycle fetch is wrong-path and dropped.
                        r_out_valid <= 1'b0;
                        if (w_fire) begin
                            r_pc <= w_tgt;
                        end else begin
                            r_tgt   <= w_tgt;
                            r_state <= c_SQUASH;
                        end
                    end else if (w_fire) begin
                        if (!r_out_valid || w_consume) begin
                            r_out_valid <= 1'b1;
                            r_out_inst  <= imem_rdata;
                            r_out_pc    <= imem_addr;
                        end else begin
                            r_skid_inst <= imem_rdata;
                            r_skid_pc   <= imem_addr;
                            r_state     <= c_SKID;
                        end
                        r_pc <= w_pc_inc;
                    end else if (w_consume) begin
                        r_out_valid <= 1'b0;
                    end
`endif
                end
                c_SKID: begin
                    // Output is always full here; r_pc already points past
                    // the skid word and no request is in flight.
                    if (w_consume) begin
`ifdef IFETCH_DELAY_SLOT_EN
                        r_out_inst <= r_skid_inst;
                        r_out_pc   <= r_skid_pc;
                        if (w_redirect) begin
                            r_pc <= w_tgt;
                        end
`else
                        if (w_redirect) begin
                            r_out_valid <= 1'b0;
                            r_pc        <= w_tgt;
                        end else begin
                            r_out_inst <= r_skid_inst;
                            r_out_pc   <= r_skid_pc;
                        end
`endif
                        r_state <= c_RUN;
                    end
                end
                c_SQUASH: begin
                    // Hold the old address until memory completes, then
                    // discard the data and resume at the redirect target.
                    if (w_fire) begin
                        r_pc    <= r_tgt;
                        r_state <= c_RUN;
                    end
                end
                default: begin
                    r_state <= c_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Self-checking bench for inst_fetch with a wait-state memory
//            model and a scoreboard of expected delivered instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [5:0]  opcode;

    int          checks = 0;
    int          errors = 0;
    int          waits  = 0;
    int          wcnt   = 0;
    logic [31:0] exp_q[$];

    inst_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .opcode      (opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[7:2], ~a[27:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: memory responds, consumed instructions are scored,
    // then the edge happens and the wait counter advances.
    task automatic cyc();
        logic        req_b;
        logic        fire_b;
        logic [31:0] e;
        logic [31:0] w;
        #1;
        if (imem_req === 1'b1 && wcnt >= waits) begin
            imem_ready = 1'b1;
            imem_rdata = memword(imem_addr);
        end else begin
            imem_ready = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
        #1;
        if (if_valid === 1'b1 && stall === 1'b0) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra observed_pc=%h expected=none", if_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                w = memword(e);
                chk("sb_pc", if_pc, e);
                chk("sb_inst", if_inst, w);
                chk("sb_opcode", {26'd0, opcode}, {26'd0, w[31:26]});
            end
        end
        req_b  = imem_req;
        fire_b = imem_req && imem_ready;
        @(posedge clk);
        #1;
        if (fire_b || !req_b) wcnt = 0;
        else                  wcnt++;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            cyc();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b0;
        imem_rdata  = 32'd0;

        // Reset state
        repeat (3) cyc();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_opcode", {26'd0, opcode}, 32'd0);

        // Zero-wait streaming from RESET_PC
        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h100);
        chk("first_valid", {31'd0, if_valid}, 32'd0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        cyc();
        chk("zw_valid", {31'd0, if_valid}, 32'd1);
        chk("zw_pc", if_pc, 32'h100);
        chk("zw_addr", imem_addr, 32'h104);
        cyc();
        chk("zw_addr2", imem_addr, 32'h108);
        cyc();
        chk("zw_addr3", imem_addr, 32'h10C);

        // Stall for 4 cycles: one word goes to the skid, request stops
        stall = 1'b1;
        exp_q.push_back(32'h10C);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_pc", if_pc, 32'h108);
            chk("stall_inst", if_inst, memword(32'h108));
        end
        stall = 1'b0;
        cyc();
        chk("skid_pc", if_pc, 32'h10C);
        chk("skid_valid", {31'd0, if_valid}, 32'd1);
        chk("skid_addr", imem_addr, 32'h110);
        chk("skid_req", {31'd0, imem_req}, 32'd1);

        // Redirect to 0x2002 while the fetch of 0x110 waits (2 wait states)
        waits       = 2;
        redirect    = 1'b1;
        redirect_pc = 32'h2002;
`ifdef IFETCH_DELAY_SLOT_EN
        exp_q.push_back(32'h110);
`endif
        exp_q.push_back(32'h2000);
        cyc();
        redirect = 1'b0;
        chk("rd_valid", {31'd0, if_valid}, 32'd0);
        chk("rd_hold_addr", imem_addr, 32'h110);
        chk("rd_hold_req", {31'd0, imem_req}, 32'd1);
        cyc();
        chk("rd_hold_addr2", imem_addr, 32'h110);
        cyc();
        chk("rd_new_addr", imem_addr, 32'h2000);
`ifdef IFETCH_DELAY_SLOT_EN
        chk("rd_slot_valid", {31'd0, if_valid}, 32'd1);
        chk("rd_slot_pc", if_pc, 32'h110);
`else
        chk("rd_squash_valid", {31'd0, if_valid}, 32'd0);
`endif
        // Two wait states on the new address
        cyc();
        chk("ws_addr0", imem_addr, 32'h2000);
        chk("ws_valid0", {31'd0, if_valid}, 32'd0);
        cyc();
        chk("ws_addr1", imem_addr, 32'h2000);
        chk("ws_valid1", {31'd0, if_valid}, 32'd0);
        cyc();
        chk("ws_valid2", {31'd0, if_valid}, 32'd1);
        chk("ws_pc", if_pc, 32'h2000);
        chk("ws_addr2", imem_addr, 32'h2004);

        // Fill the skid, then reset mid-operation
        waits = 0;
        stall = 1'b1;
        cyc();
        chk("pre_rst_req", {31'd0, imem_req}, 32'd0);
        exp_q.delete();
        rst = 1'b1;
        cyc();
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_pc", if_pc, 32'd0);
        rst   = 1'b0;
        stall = 1'b0;
        #1;
        chk("post_rst_addr", imem_addr, 32'h100);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);

        // Redirect to the top of memory: masking of bits [1:0] and PC wrap
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
`ifdef IFETCH_DELAY_SLOT_EN
        exp_q.push_back(32'h108);
`endif
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        cyc();
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        cyc();
        redirect = 1'b0;
        chk("wrap_tgt_addr", imem_addr, 32'hFFFF_FFFC);
`ifdef IFETCH_DELAY_SLOT_EN
        chk("wrap_slot_pc", if_pc, 32'h108);
`else
        chk("wrap_flush_valid", {31'd0, if_valid}, 32'd0);
`endif
        cyc();
        chk("wrap_addr", imem_addr, 32'h0);
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
